// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR pattern generator / signature compactor family.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_GEN  = 1'b0,
    MODE_MISR = 1'b1
  } mode_t;

  // Maximal-length feedback masks; bit i set means dff[i] enters the XOR.
  function automatic logic [31:0] default_taps(input int width);
    logic [31:0] taps;
    case (width)
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      9:       taps = 32'h0000_0110;
      10:      taps = 32'h0000_0240;
      11:      taps = 32'h0000_0500;
      12:      taps = 32'h0000_0829;
      13:      taps = 32'h0000_100D;
      14:      taps = 32'h0000_2015;
      15:      taps = 32'h0000_6000;
      16:      taps = 32'h0000_D008;
      17:      taps = 32'h0001_2000;
      18:      taps = 32'h0002_0400;
      19:      taps = 32'h0004_0023;
      20:      taps = 32'h0009_0000;
      21:      taps = 32'h0014_0000;
      22:      taps = 32'h0030_0000;
      23:      taps = 32'h0042_0000;
      24:      taps = 32'h00E1_0000;
      25:      taps = 32'h0120_0000;
      26:      taps = 32'h0200_0023;
      27:      taps = 32'h0400_0013;
      28:      taps = 32'h0900_0000;
      29:      taps = 32'h1400_0000;
      30:      taps = 32'h2000_0029;
      31:      taps = 32'h4800_0000;
      32:      taps = 32'h8020_0003;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_bist_if.sv
// Control, data and scan signals between the test controller and lfsr_bist.
interface lfsr_bist_if #(
    parameter int NBIT  = 8,
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             abort;
    logic             mode;
    logic [NBIT-1:0]  seed;
    logic [CNT_W-1:0] num_patterns;
    logic [NBIT-1:0]  data_in;
    logic             scan_en;
    logic             scan_in;
    logic [NBIT-1:0]  out;
    logic             valid;
    logic             busy;
    logic             done;
    logic             scan_out;

    modport master (
        output start, abort, mode, seed, num_patterns, data_in, scan_en, scan_in,
        input  out, valid, busy, done, scan_out
    );

    modport slave (
        input  start, abort, mode, seed, num_patterns, data_in, scan_en, scan_in,
        output out, valid, busy, done, scan_out
    );
endinterface

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step; in MISR mode the input word is folded into the shifted value.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int              NBIT = 8,
    parameter logic [NBIT-1:0] TAPS = NBIT'(default_taps(NBIT))
) (
    input  logic [NBIT-1:0] dff,
    input  mode_t           mode,
    input  logic [NBIT-1:0] data_in,
    output logic [NBIT-1:0] nxt
);
    logic fb;

    always_comb begin
        fb  = ^(dff & TAPS);
        nxt = {dff[NBIT-2:0], fb};
        if (mode == MODE_MISR) begin
            nxt = nxt ^ data_in;
        end
    end
endmodule

// File: rtl/lfsr_bist.sv
// Counted-burst BIST pattern generator / MISR with a serial scan path through its state register.
module lfsr_bist
    import lfsr_pkg::*;
#(
    parameter int              NBIT  = 8,
    parameter logic [NBIT-1:0] TAPS  = NBIT'(default_taps(NBIT)),
    parameter int              CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    lfsr_bist_if.slave bus
);
    state_t           state;
    mode_t            mode_q;
    logic [NBIT-1:0]  dff;
    logic [NBIT-1:0]  step_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_q;

    lfsr_step #(
        .NBIT (NBIT),
        .TAPS (TAPS)
    ) u_step (
        .dff     (dff),
        .mode    (mode_q),
        .data_in (bus.data_in),
        .nxt     (step_nxt)
    );

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mode_q <= MODE_GEN;
            dff    <= '0;
            cnt    <= '0;
            n_q    <= '0;
        end else if (bus.abort) begin
            // Abort wins over everything; the register keeps its value for inspection.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mode_q <= mode_t'(bus.mode);
                        n_q    <= bus.num_patterns;
                        cnt    <= '0;
                        // An all-zero seed would lock the generator, so GEN substitutes 1.
                        if (mode_t'(bus.mode) == MODE_GEN && bus.seed == '0) begin
                            dff <= NBIT'(1);
                        end else begin
                            dff <= bus.seed;
                        end
                        state <= (bus.num_patterns != '0) ? RUN : DONE;
                    end else if (bus.scan_en) begin
                        dff   <= {dff[NBIT-2:0], bus.scan_in};
                        state <= IDLE;
                    end
                end
                RUN: begin
                    dff <= step_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == n_q - CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out      = dff;
    assign bus.valid    = (state == RUN);
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.scan_out = dff[NBIT-1];
endmodule

// File: tb/tb_lfsr_bist.sv
// Directed bench for lfsr_bist at NBIT=4, TAPS=4'hC with hand-computed expected sequences.
module tb_lfsr_bist;
    localparam int NBIT  = 4;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    lfsr_bist_if #(.NBIT(NBIT), .CNT_W(CNT_W)) bus ();

    lfsr_bist #(
        .NBIT  (NBIT),
        .TAPS  (4'hC),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input logic m, input logic [NBIT-1:0] s, input logic [CNT_W-1:0] n);
        bus.start        = 1'b1;
        bus.mode         = m;
        bus.seed         = s;
        bus.num_patterns = n;
        tick();
        bus.start = 1'b0;
    endtask

    logic [3:0] gen5  [5]  = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3};
    logic [3:0] gen15 [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [3:0] scan_bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] model;

    initial begin
        rst              = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.mode         = 1'b0;
        bus.seed         = '0;
        bus.num_patterns = '0;
        bus.data_in      = '0;
        bus.scan_en      = 1'b0;
        bus.scan_in      = 1'b0;
        tick();
        tick();
        check("reset_out", bus.out, 4'h0);
        check("reset_flags", {bus.valid, bus.busy, bus.done, bus.scan_out}, 4'b0000);
        #2 rst = 1'b1;
        tick();

        // abort beats start in IDLE
        bus.abort = 1'b1;
        start_burst(1'b0, 4'h1, 16'd5);
        bus.abort = 1'b0;
        check("abort_beats_start", {bus.busy, bus.done}, 2'b00);

        // GEN seed 1, N=5
        start_burst(1'b0, 4'h1, 16'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("gen5_valid[%0d]", i), {bus.valid, bus.busy}, 2'b11);
            check($sformatf("gen5_out[%0d]", i), bus.out, gen5[i]);
            tick();
        end
        check("gen5_done", {bus.valid, bus.done}, 2'b01);
        check("gen5_final", bus.out, 4'h6);
        tick();
        check("gen5_done_hold", bus.done, 1'b1);

        // GEN full period, started from DONE
        start_burst(1'b0, 4'h1, 16'd15);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("gen15_out[%0d]", i), {bus.valid, bus.out}, {1'b1, gen15[i]});
            tick();
        end
        check("gen15_done", bus.done, 1'b1);
        check("gen15_final", bus.out, 4'h1);

        // GEN zero seed substitutes 1
        start_burst(1'b0, 4'h0, 16'd1);
        check("zero_seed_out", {bus.valid, bus.out}, {1'b1, 4'h1});
        tick();
        check("zero_seed_done", {bus.done, bus.out}, {1'b1, 4'h2});

        // scan in DONE shifts and drops to IDLE
        bus.scan_en = 1'b1;
        bus.scan_in = 1'b0;
        tick();
        bus.scan_en = 1'b0;
        check("done_scan_idle", {bus.done, bus.busy, bus.out}, {2'b00, 4'h4});

        // MISR seed 0, data_in 1, N=2
        bus.data_in = 4'h1;
        start_burst(1'b1, 4'h0, 16'd2);
        check("misr_out0", {bus.valid, bus.out}, {1'b1, 4'h0});
        tick();
        check("misr_out1", bus.out, 4'h1);
        tick();
        check("misr_signature", {bus.done, bus.out}, {1'b1, 4'h3});

        // MISR aborted after one cycle
        start_burst(1'b1, 4'h0, 16'd2);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_state", {bus.busy, bus.done, bus.valid}, 3'b000);
        check("abort_out", bus.out, 4'h1);

        // serial scan from IDLE
        model       = bus.out;
        bus.scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.scan_in = scan_bits[i][0];
            check($sformatf("scan_out[%0d]", i), bus.scan_out, model[3]);
            tick();
            model = {model[2:0], scan_bits[i][0]};
        end
        bus.scan_en = 1'b0;
        check("scan_result", bus.out, 4'hB);
        check("scan_idle", {bus.busy, bus.done}, 2'b00);

        // start beats scan_en; start during RUN is ignored
        bus.scan_en = 1'b1;
        bus.scan_in = 1'b0;
        start_burst(1'b0, 4'h5, 16'd2);
        bus.scan_en = 1'b0;
        check("start_over_scan", {bus.busy, bus.out}, {1'b1, 4'h5});
        bus.start        = 1'b1;
        bus.seed         = 4'h9;
        bus.num_patterns = 16'd7;
        tick();
        bus.start = 1'b0;
        check("start_in_run_ignored", {bus.busy, bus.out}, {1'b1, 4'hB});
        tick();
        check("short_burst_done", {bus.done, bus.out}, {1'b1, 4'h7});

        // asynchronous reset mid-RUN
        start_burst(1'b0, 4'h1, 16'd5);
        tick();
        check("pre_reset_run", {bus.busy, bus.out}, {1'b1, 4'h2});
        #2 rst = 1'b0;
        #1;
        check("midrun_reset_out", bus.out, 4'h0);
        check("midrun_reset_flags", {bus.valid, bus.busy, bus.done, bus.scan_out}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("post_reset_idle", {bus.busy, bus.done, bus.out}, {2'b00, 4'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfsr_bist.md
# lfsr_bist

Parametrised BIST pattern generator and signature compactor. It is the next generation of the team's 4-bit LFSR, with configurable width and feedback polynomial. The block runs a counted burst of N pseudo-random patterns (GEN mode), or compacts N input words into a signature (MISR mode). It sits between the scan/test controller and the circuit under test, and keeps the serial scan path through its state register.

## Interface
- NBIT, 8, register width (≥3)
- TAPS, 8'hB8, feedback mask; bit i set means dff[i] enters the XOR feedback
- CNT_W, 16, pattern-counter width
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin burst (honoured in IDLE/DONE only)
- abort  input  1  terminate burst, return to IDLE
- mode  input  1  0 = GEN, 1 = MISR; sampled with start
- seed  input  NBIT  initial register value; sampled with start
- num_patterns  input  CNT_W  burst length N; sampled with start
- data_in  input  NBIT  MISR input word, sampled each RUN cycle
- scan_en  input  1  serial shift enable (IDLE/DONE only)
- scan_in  input  1  serial input, enters dff[0]
- out  output  NBIT  current register value (dff)
- valid  output  1  out is a live pattern (RUN only)
- busy  output  1  state is RUN
- done  output  1  state is DONE
- scan_out  output  1  dff[NBIT-1]

## Operation
- Feedback: fb = XOR over i of (dff[i] & TAPS[i]). Step: next = {dff[NBIT-2:0], fb}.
- MISR step: next = {dff[NBIT-2:0], fb} ^ data_in.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1, abort=0:
  - latch mode and N; dff <= seed; cnt <= 0.
  - Next state is RUN if N≠0, otherwise DONE.
- GEN with seed==0: dff loads 1 (lockup avoidance). MISR accepts a zero seed.
- RUN, each cycle:
  - valid=1; dff steps per the latched mode; cnt <= cnt+1.
  - When cnt==N-1, next state is DONE.
  - Exactly N valid cycles; GEN out sequence is seed, step(seed), …
- DONE: out holds the final dff (signature in MISR). done stays 1 until start, abort or scan activity.
- abort: any state goes to IDLE; dff holds; cnt cleared. abort beats start.
- start during RUN: ignored.
- Scan: scan_en=1 in IDLE/DONE gives dff <= {dff[NBIT-2:0], scan_in}; DONE goes to IDLE. start beats scan_en; scan_en is ignored in RUN.
- Counter wrap: not possible (cnt < N ≤ 2^CNT_W-1).

## Timing
- Reset (asynchronous, immediate, including mid-RUN): dff=0, cnt=0, state IDLE, out=0, valid=0, busy=0, done=0, scan_out=0.
- Start-to-first-valid latency: 1 cycle. busy and valid rise in the cycle after the start edge.
- done rises in the cycle after the last valid cycle.
- All outputs are registered or direct decodes of state/dff. No combinational input-to-output path.

## Structure
- Package lfsr_pkg:
  - state encoding constants (IDLE, RUN, DONE)
  - mode constants (MODE_GEN, MODE_MISR)
  - default maximal-length tap masks for widths 4–32 (e.g. 4'hC, 8'hB8)
- Sub-module lfsr_step (combinational):
  - inputs: dff, TAPS, mode, data_in
  - output: next register value
  - reused by the future parallel-MISR block
- The top holds the FSM, counter and scan mux.

## Test plan
All scenarios use NBIT=4, TAPS=4'hC.
- Reset: rst low mid-RUN → all outputs 0 in the same cycle; state IDLE after release.
- GEN: seed 4'h1, N=5 → valid for 5 cycles with out 1,2,4,9,3; then done=1, out=4'h6.
- GEN wrap: seed 4'h1, N=15 → 15 distinct values, last 4'h8; DONE out=4'h1 (period 15).
- GEN zero seed: seed 0, N=1 → single valid pattern 4'h1.
- MISR: seed 0, data_in=4'h1, N=2 → signature 4'h3. abort after 1 cycle → IDLE, out=4'h1.
- Scan: IDLE, scan_en=1, scan_in 1,0,1,1 → out=4'hB. scan_out tracks the prior dff[3] each cycle. start asserted together with scan_en → burst starts, no shift.
